// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter.
//   state_e : arbiter FSM states (idle, request on bus, waiting for response, response pulse)
//   owner_e : which requester owns the current transaction
package mem_bus_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StResp = 2'd3
    } state_e;

    typedef enum logic {
        OwnIf  = 1'b0,
        OwnMem = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_bus_req_reg.sv
// Latched bus request fields for the arbiter.
// Captures owner/we/addr/wdata/wmask when load is high; holds them otherwise.
//   clk, rst          : clock and synchronous active-high reset (clears all fields)
//   load              : capture the ld_* inputs this cycle
//   ld_*              : request fields to capture
//   owner, we, addr,
//   wdata, wmask      : currently latched request
module mem_bus_req_reg
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  owner_e              ld_owner,
    input  logic                ld_we,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_wdata,
    input  logic [DATA_W/8-1:0] ld_wmask,
    output owner_e              owner,
    output logic                we,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wmask
);

    owner_e                owner_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OwnIf;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (load) begin
            owner_q <= ld_owner;
            we_q    <= ld_we;
            addr_q  <= ld_addr;
            wdata_q <= ld_wdata;
            wmask_q <= ld_wmask;
        end
    end

    assign owner = owner_q;
    assign we    = we_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;
    assign wmask = wmask_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus port between instruction fetch (IF) and load/store (MEM).
// MEM has fixed priority. One transaction at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   clk, rst                     : clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_flush_i: fetch request, address, flush of current fetch
//   if_rdata_o/if_rvalid_o       : fetch data and one-cycle completion pulse
//   if_stall_o                   : fetch pending and not completing this cycle
//   mem_req_i/mem_we_i/mem_addr_i/mem_wdata_i/mem_wmask_i : load/store request
//   mem_rdata_o/mem_done_o       : load data and one-cycle completion pulse
//   mem_stall_o                  : load/store pending and not completing this cycle
//   bus_valid_o/bus_ready_i      : request handshake to the slave
//   bus_we_o/bus_addr_o/bus_wdata_o/bus_wmask_o : latched request fields
//   bus_rvalid_i/bus_rdata_i     : slave response
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_rvalid_o,
    output logic                if_stall_o,
    input  logic                mem_req_i,
    input  logic                mem_we_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    input  logic [DATA_W/8-1:0] mem_wmask_i,
    output logic [DATA_W-1:0]   mem_rdata_o,
    output logic                mem_done_o,
    output logic                mem_stall_o,
    output logic                bus_valid_o,
    input  logic                bus_ready_i,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_wmask_o,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    state_e              state_q;
    logic                drop_q;
    logic                if_rvalid_q;
    logic                mem_done_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   mem_rdata_q;

    logic                grant;
    owner_e              grant_owner;
    logic                ld_we;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_wdata;
    logic [DATA_W/8-1:0] ld_wmask;
    owner_e              owner;

    // Grant only from IDLE; a fetch being flushed in the same cycle is not started.
    always_comb begin
        grant       = 1'b0;
        grant_owner = OwnIf;
        ld_we       = 1'b0;
        ld_addr     = if_addr_i;
        ld_wdata    = '0;
        ld_wmask    = '0;
        if (state_q == StIdle) begin
            if (mem_req_i) begin
                grant       = 1'b1;
                grant_owner = OwnMem;
                ld_we       = mem_we_i;
                ld_addr     = mem_addr_i;
                ld_wdata    = mem_wdata_i;
                ld_wmask    = mem_wmask_i;
            end else if (if_req_i && !if_flush_i) begin
                grant       = 1'b1;
            end
        end
    end

    mem_bus_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .ld_owner (grant_owner),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_wmask (ld_wmask),
        .owner    (owner),
        .we       (bus_we_o),
        .addr     (bus_addr_o),
        .wdata    (bus_wdata_o),
        .wmask    (bus_wmask_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            drop_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            mem_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    drop_q <= 1'b0;
                    if (grant) state_q <= StReq;
                end
                StReq: begin
                    if (bus_ready_i) state_q <= StWait;
                    if (owner == OwnIf && if_flush_i) drop_q <= 1'b1;
                end
                StWait: begin
                    if (owner == OwnIf && if_flush_i) drop_q <= 1'b1;
                    if (bus_rvalid_i) begin
                        state_q <= StResp;
                        if (owner == OwnMem) begin
                            mem_rdata_q <= bus_rdata_i;
                            mem_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q  <= bus_rdata_i;
                            // A flush arriving with the response also suppresses the pulse.
                            if_rvalid_q <= !(drop_q || if_flush_i);
                        end
                    end
                end
                StResp: begin
                    drop_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_valid_o = (state_q == StReq);
    assign if_rvalid_o = if_rvalid_q;
    assign mem_done_o  = mem_done_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_stall_o  = if_req_i && !if_rvalid_q;
    assign mem_stall_o = mem_req_i && !mem_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized rounds.
// A bench-side slave answers requests with programmable delays and logs what it accepted.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [63:0] if_rdata_o;
    logic        if_rvalid_o;
    logic        if_stall_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [63:0] mem_wdata_i;
    logic [7:0]  mem_wmask_i;
    logic [63:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_stall_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [63:0] bus_wdata_o;
    logic [7:0]  bus_wmask_o;
    logic        bus_rvalid_i;
    logic [63:0] bus_rdata_i;

    mem_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_flush_i   (if_flush_i),
        .if_rdata_o   (if_rdata_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_stall_o   (if_stall_o),
        .mem_req_i    (mem_req_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_wmask_i  (mem_wmask_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_done_o   (mem_done_o),
        .mem_stall_o  (mem_stall_o),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_wmask_o  (bus_wmask_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    int total = 0;
    int bad   = 0;

    // Slave behaviour knobs (written by the main sequence) and its acceptance log.
    int          rdy_dly = 0;
    int          rv_dly  = 0;
    int          unstable = 0;
    logic [31:0] q_addr[$];
    logic        q_we[$];
    logic [63:0] q_wdata[$];
    logic [7:0]  q_wmask[$];
    int          log_rd = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] sdata(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    // Slave: drives at negedges, so the DUT samples stable values at the next posedge.
    initial begin
        logic [31:0] c_addr;
        logic        c_we;
        logic [63:0] c_wdata;
        logic [7:0]  c_wmask;
        bus_ready_i  = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (bus_valid_o) begin
                c_addr  = bus_addr_o;
                c_we    = bus_we_o;
                c_wdata = bus_wdata_o;
                c_wmask = bus_wmask_o;
                for (int k = 0; k < rdy_dly; k++) begin
                    @(negedge clk);
                    if (bus_valid_o && (bus_addr_o !== c_addr || bus_we_o !== c_we ||
                                        bus_wdata_o !== c_wdata || bus_wmask_o !== c_wmask))
                        unstable++;
                end
                bus_ready_i = 1'b1;
                q_addr.push_back(c_addr);
                q_we.push_back(c_we);
                q_wdata.push_back(c_wdata);
                q_wmask.push_back(c_wmask);
                @(negedge clk);
                bus_ready_i = 1'b0;
                repeat (rv_dly) @(negedge clk);
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = sdata(c_addr);
                @(negedge clk);
                bus_rvalid_i = 1'b0;
                bus_rdata_i  = {$urandom, $urandom};
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input bit ev, input bit eifv, input bit emd,
                               input bit eifs, input bit ems);
        chk({tag, ":bus_valid"}, {63'd0, bus_valid_o}, {63'd0, ev});
        chk({tag, ":if_rvalid"}, {63'd0, if_rvalid_o}, {63'd0, eifv});
        chk({tag, ":mem_done"}, {63'd0, mem_done_o}, {63'd0, emd});
        chk({tag, ":if_stall"}, {63'd0, if_stall_o}, {63'd0, eifs});
        chk({tag, ":mem_stall"}, {63'd0, mem_stall_o}, {63'd0, ems});
    endtask

    // One round from IDLE. Model: with d = ready + rvalid wait states, the first grant
    // completes at 3+d; a second (IF after MEM) is granted at the following IDLE cycle
    // and completes 4+d later. Requests drop right after their pulse.
    task automatic run_round(input string tag, input bit use_if, input bit use_mem,
                             input logic [31:0] ia, input logic mwe, input logic [31:0] ma,
                             input logic [63:0] wd, input logic [7:0] wm,
                             input int rd, input int rv);
        int d, e1, e_if, e_mem, last, n;
        bit v;
        d     = rd + rv;
        e1    = 3 + d;
        e_mem = use_mem ? e1 : -1;
        e_if  = use_if ? (use_mem ? e1 + 4 + d : e1) : -1;
        last  = (use_if && use_mem) ? e_if : e1;
        rdy_dly = rd;
        rv_dly  = rv;
        if_req_i    = use_if;
        if_addr_i   = ia;
        mem_req_i   = use_mem;
        mem_we_i    = mwe;
        mem_addr_i  = ma;
        mem_wdata_i = wd;
        mem_wmask_i = wm;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clk);
            v = (c >= 1 && c <= 1 + rd) ||
                (use_if && use_mem && c >= e1 + 2 && c <= e1 + 2 + rd);
            check_cycle(tag, v, c == e_if, c == e_mem, use_if && c < e_if, use_mem && c < e_mem);
            if (c == e_if)  chk({tag, ":if_rdata"}, if_rdata_o, sdata(ia));
            if (c == e_mem) chk({tag, ":mem_rdata"}, mem_rdata_o, sdata(ma));
            tick();
            if (c == e_if)  if_req_i  = 1'b0;
            if (c == e_mem) mem_req_i = 1'b0;
        end
        n = int'(use_if) + int'(use_mem);
        chk({tag, ":log_count"}, 64'(q_addr.size()), 64'(log_rd + n));
        if (q_addr.size() >= log_rd + n) begin
            if (use_mem) begin
                chk({tag, ":mem_addr"}, {32'd0, q_addr[log_rd]}, {32'd0, ma});
                chk({tag, ":mem_we"}, {63'd0, q_we[log_rd]}, {63'd0, mwe});
                chk({tag, ":mem_wdata"}, q_wdata[log_rd], wd);
                chk({tag, ":mem_wmask"}, {56'd0, q_wmask[log_rd]}, {56'd0, wm});
                log_rd++;
            end
            if (use_if) begin
                chk({tag, ":if_addr"}, {32'd0, q_addr[log_rd]}, {32'd0, ia});
                chk({tag, ":if_we"}, {63'd0, q_we[log_rd]}, 64'd0);
                chk({tag, ":if_wmask"}, {56'd0, q_wmask[log_rd]}, 64'd0);
                log_rd++;
            end
        end else begin
            log_rd = q_addr.size();
        end
    endtask

    initial begin
        int mode;
        rst         = 1'b1;
        if_req_i    = 1'b1;
        if_addr_i   = '0;
        if_flush_i  = 1'b0;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;
        mem_wmask_i = '0;

        // Reset values; stalls follow requests even in reset.
        repeat (3) tick();
        @(negedge clk);
        chk("rst:bus_valid", {63'd0, bus_valid_o}, 64'd0);
        chk("rst:if_rvalid", {63'd0, if_rvalid_o}, 64'd0);
        chk("rst:mem_done", {63'd0, mem_done_o}, 64'd0);
        chk("rst:if_rdata", if_rdata_o, 64'd0);
        chk("rst:mem_rdata", mem_rdata_o, 64'd0);
        chk("rst:bus_addr", {32'd0, bus_addr_o}, 64'd0);
        chk("rst:bus_we", {63'd0, bus_we_o}, 64'd0);
        chk("rst:bus_wdata", bus_wdata_o, 64'd0);
        chk("rst:bus_wmask", {56'd0, bus_wmask_o}, 64'd0);
        chk("rst:if_stall_req", {63'd0, if_stall_o}, 64'd1);
        chk("rst:mem_stall_req", {63'd0, mem_stall_o}, 64'd1);
        tick();
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        @(negedge clk);
        chk("rst:if_stall_idle", {63'd0, if_stall_o}, 64'd0);
        chk("rst:mem_stall_idle", {63'd0, mem_stall_o}, 64'd0);
        tick();
        rst = 1'b0;

        run_round("single_fetch", 1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0, 64'h0, 8'h0, 0, 0);
        run_round("conflict", 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h0000_0100,
                  64'hDEAD_BEEF, 8'h0F, 0, 0);
        run_round("wait_states", 1'b1, 1'b0, 32'h0000_3000, 1'b0, 32'h0, 64'h0, 8'h0, 3, 2);
        run_round("load_waits", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_0200, 64'h0, 8'h0, 1, 1);

        // Flush during WAIT: old response drains silently, new fetch follows.
        rdy_dly    = 0;
        rv_dly     = 2;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_4000;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            check_cycle("flush", c == 1 || c == 7, c == 11, 1'b0, c < 11, 1'b0);
            if (c == 11) chk("flush:if_rdata", if_rdata_o, sdata(32'h8000_0040));
            tick();
            if (c == 1) begin
                if_flush_i = 1'b1;
                if_addr_i  = 32'h8000_0040;
            end
            if (c == 2)  if_flush_i = 1'b0;
            if (c == 11) if_req_i   = 1'b0;
        end
        chk("flush:log_count", 64'(q_addr.size()), 64'(log_rd + 2));
        if (q_addr.size() >= log_rd + 2) begin
            chk("flush:old_addr", {32'd0, q_addr[log_rd]}, 64'h0000_4000);
            chk("flush:new_addr", {32'd0, q_addr[log_rd + 1]}, 64'h8000_0040);
        end
        log_rd = q_addr.size();

        // Reset while REQ is on the bus; the slave answers late and must be ignored.
        rdy_dly   = 3;
        rv_dly    = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_5000;
        @(negedge clk);
        chk("rstmid:valid_c0", {63'd0, bus_valid_o}, 64'd0);
        tick();
        rst      = 1'b1;
        if_req_i = 1'b0;
        @(negedge clk);
        chk("rstmid:valid_c1", {63'd0, bus_valid_o}, 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid:bus_addr", {32'd0, bus_addr_o}, 64'd0);
        chk("rstmid:if_rdata", if_rdata_o, 64'd0);
        chk("rstmid:mem_rdata", mem_rdata_o, 64'd0);
        check_cycle("rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            check_cycle("rstmid_tail", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rstmid_tail:if_rdata", if_rdata_o, 64'd0);
        end
        tick();
        log_rd  = q_addr.size();
        rdy_dly = 0;

        for (int i = 0; i < 20; i++) begin
            mode = int'($urandom_range(1, 3));
            run_round("random", mode[0], mode[1], $urandom, 1'($urandom), $urandom,
                      {$urandom, $urandom}, 8'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end

        chk("fields_stable", 64'(unstable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
